// File: rtl/jac_to_affine.sv
// jac_to_affine: converts a Jacobian point (X, Y) to affine coordinates using
// the already inverted Z coordinate. It computes x = X*Zinv^2 mod M and
// y = Y*Zinv^3 mod M. One bit-serial interleaved modular multiplier is reused
// for four products.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          request strobe, sampled only while idle
//   opX, opY, opZinv  operands, each < opM
//   opM               modulus, 2 <= M < 2^WIDTH
//   busy              high from accept through the out_valid cycle
//   out_valid         one-cycle result pulse
//   out_x, out_y      affine result, held until the next out_valid
//   out_inf           point-at-infinity flag, qualified by out_valid
//
// Build option: when J2A_INF_CHECK_EN is defined, a request with Zinv == 0
// skips the multiplies. It reports out_inf=1 two cycles after accept.
//
// state | meaning
// IDLE  | wait for in_valid, latch operands
// LOAD  | select step-0 operands, clear accumulator
// MUL   | one multiplier iteration per cycle, WIDTH cycles
// NEXT  | store product of step k; for k<3 also load step k+1 (acts as LOAD)
// DONE  | out_valid pulse
module jac_to_affine #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opX,
    input  logic [WIDTH-1:0] opY,
    input  logic [WIDTH-1:0] opZinv,
    input  logic [WIDTH-1:0] opM,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_inf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_NEXT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] x_r, y_r, zi_r, m_r;
    logic [WIDTH-1:0] t2_r, t3_r, rx_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH+1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       k_r;
    logic             inf_r;

    logic [1:0]       sel_k;
    logic [WIDTH-1:0] t2_src, op_a, op_b;
    logic [WIDTH+1:0] s0, s1, m_ext, acc_nxt;

    // Operand select for the step being loaded. In NEXT with k=0, t2 is
    // still in the accumulator, so it is forwarded directly.
    always_comb begin
        sel_k  = (state == S_NEXT) ? k_r + 2'd1 : k_r;
        t2_src = (state == S_NEXT && k_r == 2'd0) ? acc_r[WIDTH-1:0] : t2_r;
        case (sel_k)
            2'd0:    begin op_a = zi_r;   op_b = zi_r;   end
            2'd1:    begin op_a = t2_src; op_b = zi_r;   end
            2'd2:    begin op_a = x_r;    op_b = t2_src; end
            default: begin op_a = y_r;    op_b = t3_r;   end
        endcase
    end

    // One interleaved iteration. Here acc < M and a < M, so 2*acc + a < 3M.
    // Two conditional subtracts therefore fully reduce the result.
    always_comb begin
        m_ext   = {2'b00, m_r};
        s0      = (acc_r << 1) + (b_r[WIDTH-1] ? {2'b00, a_r} : '0);
        s1      = (s0 >= m_ext) ? s0 - m_ext : s0;
        acc_nxt = (s1 >= m_ext) ? s1 - m_ext : s1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = S_LOAD;
            S_LOAD: begin
`ifdef J2A_INF_CHECK_EN
                state_nxt = (zi_r == '0) ? S_NEXT : S_MUL;
`else
                state_nxt = S_MUL;
`endif
            end
            S_MUL:  if (cnt_r == '0) state_nxt = S_NEXT;
            S_NEXT: state_nxt = (k_r == 2'd3) ? S_DONE : S_MUL;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0; y_r <= '0; zi_r <= '0; m_r <= '0;
            t2_r <= '0; t3_r <= '0; rx_r <= '0;
            a_r <= '0; b_r <= '0; acc_r <= '0;
            cnt_r <= '0; k_r <= '0; inf_r <= 1'b0;
            out_x <= '0; out_y <= '0; out_inf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x_r   <= opX;
                    y_r   <= opY;
                    zi_r  <= opZinv;
                    m_r   <= opM;
                    rx_r  <= '0;
                    k_r   <= 2'd0;
                    inf_r <= 1'b0;
                end
                S_LOAD: begin
                    a_r   <= op_a;
                    b_r   <= op_b;
                    acc_r <= '0;
                    cnt_r <= CNT_LAST;
`ifdef J2A_INF_CHECK_EN
                    // Zinv == 0 jumps straight to the final store.
                    // rx_r and acc are zero at that point, so the outputs
                    // come out as 0.
                    if (zi_r == '0) begin
                        inf_r <= 1'b1;
                        k_r   <= 2'd3;
                    end
`endif
                end
                S_MUL: begin
                    acc_r <= acc_nxt;
                    b_r   <= b_r << 1;
                    cnt_r <= cnt_r - CW'(1);
                end
                S_NEXT: begin
                    case (k_r)
                        2'd0: t2_r <= acc_r[WIDTH-1:0];
                        2'd1: t3_r <= acc_r[WIDTH-1:0];
                        2'd2: rx_r <= acc_r[WIDTH-1:0];
                        default: begin
                            out_x   <= rx_r;
                            out_y   <= acc_r[WIDTH-1:0];
                            out_inf <= inf_r;
                        end
                    endcase
                    if (k_r != 2'd3) begin
                        k_r   <= k_r + 2'd1;
                        a_r   <= op_a;
                        b_r   <= op_b;
                        acc_r <= '0;
                        cnt_r <= CNT_LAST;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jac_to_affine.sv
module tb_jac_to_affine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

`ifdef J2A_INF_CHECK_EN
    localparam bit INF_EN = 1'b1;
`else
    localparam bit INF_EN = 1'b0;
`endif

    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic       v8, b8, ov8, inf8;
    logic [7:0] x8, y8, z8, m8, ox8, oy8;
    logic         v256, b256, ov256, inf256;
    logic [255:0] x256, y256, z256, m256, ox256, oy256;

    jac_to_affine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8),
        .opX(x8), .opY(y8), .opZinv(z8), .opM(m8),
        .busy(b8), .out_valid(ov8), .out_x(ox8), .out_y(oy8), .out_inf(inf8)
    );

    jac_to_affine #(.WIDTH(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .in_valid(v256),
        .opX(x256), .opY(y256), .opZinv(z256), .opM(m256),
        .busy(b256), .out_valid(ov256), .out_x(ox256), .out_y(oy256), .out_inf(inf256)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] m);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        return 256'(p % {256'b0, m});
    endfunction

    function automatic logic [255:0] ref_x(input logic [255:0] x, input logic [255:0] z,
                                           input logic [255:0] m);
        return mulmod(x, mulmod(z, z, m), m);
    endfunction

    function automatic logic [255:0] ref_y(input logic [255:0] y, input logic [255:0] z,
                                           input logic [255:0] m);
        return mulmod(y, mulmod(mulmod(z, z, m), z, m), m);
    endfunction

    // Called #1 after a clock edge with the 8-bit DUT idle; returns edges from accept to out_valid.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                       input logic [7:0] m, output int lat);
        x8 = x; y8 = y; z8 = z; m8 = m; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, input logic [7:0] m);
        int lat;
        logic inf_exp;
        inf_exp = INF_EN && (z == 8'd0);
        op8(x, y, z, m, lat);
        chk({tag, "_lat"}, lat, inf_exp ? 2 : 37);
        chk({tag, "_x"}, ox8, ref_x(x, z, m));
        chk({tag, "_y"}, oy8, ref_y(y, z, m));
        chk({tag, "_inf"}, inf8, inf_exp);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {ov8, b8}, 2'b00);
    endtask

    task automatic run256(input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] z, input logic [255:0] m);
        int lat;
        x256 = x; y256 = y; z256 = z; m256 = m; v256 = 1'b1;
        @(posedge clk); #1;
        v256 = 1'b0;
        lat = 0;
        while (ov256 !== 1'b1 && lat < 1200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w256_lat", lat, 1029);
        chk("w256_x", ox256, ref_x(x, z, m));
        chk("w256_y", oy256, ref_y(y, z, m));
        chk("w256_inf", inf256, 1'b0);
        @(posedge clk); #1;
    endtask

    function automatic logic [255:0] rand256(input logic [255:0] m);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r % m;
    endfunction

    initial begin
        int lat;
        int seen;
        logic [7:0] m, x, y, z;

        rst_n = 1'b0;
        v8 = 1'b0; x8 = '0; y8 = '0; z8 = '0; m8 = '0;
        v256 = 1'b0; x256 = '0; y256 = '0; z256 = '0; m256 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst8_outs", {b8, ov8, inf8, ox8, oy8}, '0);
        chk("rst256_outs", {b256, ov256, inf256}, '0);
        chk("rst256_data", ox256 | oy256, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8("m11", 8'd5, 8'd7, 8'd3, 8'd11);
        chk("m11_x_const", ox8, 8'd1);
        run8("unit_zi", 8'd200, 8'd100, 8'd1, 8'd251);
        chk("unit_zi_y_const", oy8, 8'd100);
        run8("minus1", 8'd250, 8'd250, 8'd250, 8'd251);
        chk("minus1_y_const", oy8, 8'd1);
        run8("zi_zero", 8'd5, 8'd7, 8'd0, 8'd11);

        for (int i = 0; i < 20; i++) begin
            m = 8'($urandom_range(2, 255));
            x = 8'($urandom_range(0, m - 1));
            y = 8'($urandom_range(0, m - 1));
            z = 8'($urandom_range(0, m - 1));
            run8("rand8", x, y, z, m);
        end

        // A request that arrives while busy is dropped.
        x8 = 8'd5; y8 = 8'd7; z8 = 8'd3; m8 = 8'd11; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin
                x8 = 8'd9; y8 = 8'd4; z8 = 8'd6; m8 = 8'd13; v8 = 1'b1;
            end else if (lat == 11) begin
                v8 = 1'b0;
            end
        end
        chk("drop_lat", lat, 37);
        chk("drop_x", ox8, 8'd1);
        chk("drop_y", oy8, 8'd2);

        // A request raised during DONE is accepted one cycle later.
        x8 = 8'd200; y8 = 8'd100; z8 = 8'd1; m8 = 8'd251; v8 = 1'b1;
        @(posedge clk); #1;
        chk("done_ignore_busy", b8, 1'b0);
        @(posedge clk); #1;
        chk("late_accept_busy", b8, 1'b1);
        v8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("late_lat", lat, 37);
        chk("late_x", ox8, 8'd200);
        chk("late_y", oy8, 8'd100);
        @(posedge clk); #1;

        // Reset mid-operation aborts at once, and no result appears.
        x8 = 8'd5; y8 = 8'd7; z8 = 8'd3; m8 = 8'd11; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {b8, ov8, inf8, ox8, oy8}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1 || b8 === 1'b1) seen++;
        end
        chk("abort_no_valid", seen, 0);
        run8("fresh", 8'd5, 8'd7, 8'd3, 8'd11);

        for (int i = 0; i < 40; i++) begin
            run256(rand256(P256), rand256(P256), rand256(P256), P256);
        end
        run256(P256 - 1, P256 - 1, P256 - 1, P256);
        chk("w256_minus1_y_const", oy256, 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
